// File: rtl/wifi_gate_pkg.sv
// Shared types and constants for the WiFi serial gate.
package wifi_gate_pkg;

    // Gate sequencing: hold module in reset, mask boot noise, wait for idle line, pass traffic.
    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        BOOT_MASK = 2'd1,
        WAIT_IDLE = 2'd2,
        PASS      = 2'd3
    } gate_state_e;

    // Default width of the shared state counter; must hold the largest cycle parameter.
    localparam int CNT_W_DEFAULT = 24;

    // Width of the masked falling-edge counter.
    localparam int DROP_W = 8;

endpackage

// File: rtl/wifi_serial_gate_line_glitch_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
// The output level only moves after FILTER_LEN consecutive synchronized
// samples that all disagree with it, giving 2+FILTER_LEN cycles of latency.
module line_glitch_filter #(
    parameter int   FILTER_LEN  = 3,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o
);

    localparam int             RUN_W    = $clog2(FILTER_LEN) + 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [RUN_W-1:0] run_q;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= RESET_LEVEL;
            run_q   <= '0;
        end else if (sync2_q != level_q) begin
            if (run_q == RUN_LAST) begin
                level_q <= sync2_q;
                run_q   <= '0;
            end else begin
                run_q <= run_q + RUN_W'(1);
            end
        end else begin
            run_q <= '0;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/wifi_serial_gate.sv
// Sequences the ESP module reset and gates its TX line into the host UART,
// masking boot-time noise until the line has been idle for a guard time.
module wifi_serial_gate
    import wifi_gate_pkg::*;
#(
    parameter int MIN_RST_CYCLES   = 500,
    parameter int BOOT_MASK_CYCLES = 12500000,
    parameter int IDLE_CYCLES      = 8680,
    parameter int FILTER_LEN       = 3,
    parameter int CNT_W            = CNT_W_DEFAULT
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              wifi_rst_n_in,
    output logic              wifi_rst_n_out,
    input  logic              wifi_tx_in,
    output logic              rs232_sin_out,
    input  logic              rs232_sout_in,
    input  logic              rs232_sout_oe_in,
    output logic              wifi_rx_out,
    output logic              rs232_cts_n_out,
    output logic              gate_open,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_RST_CYCLES);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_MASK_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    gate_state_e       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              reqSync1_q, reqSync2_q;
    logic              txLevel;
    logic              txLevelPrev_q;
    logic [DROP_W-1:0] dropCount_q, dropCount_d;
    logic              rstOut_q, rstOut_d;
    logic              sin_q, sin_d;
    logic              rx_q, rx_d;
    logic              ctsN_q, ctsN_d;
    logic              gate_q, gate_d;

    line_glitch_filter #(
        .FILTER_LEN  (FILTER_LEN),
        .RESET_LEVEL (1'b1)
    ) u_tx_filter (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .line_i  (wifi_tx_in),
        .level_o (txLevel)
    );

    // Plain synchronizer for the host reset request; resets to "request active".
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            reqSync1_q <= 1'b0;
            reqSync2_q <= 1'b0;
        end else begin
            reqSync1_q <= wifi_rst_n_in;
            reqSync2_q <= reqSync1_q;
        end
    end

    // State and shared counter registers, plus the previous filtered level for edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= RST_HOLD;
            count_q       <= '0;
            txLevelPrev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            txLevelPrev_q <= txLevel;
        end
    end

    // Next state and counter; an active request overrides everything and the counter restarts on any state change.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            RST_HOLD: begin
                if (count_q >= MIN_CNT) begin
                    if (reqSync2_q) begin
                        state_d = BOOT_MASK;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            BOOT_MASK: begin
                if (count_q == BOOT_LAST) begin
                    state_d = WAIT_IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (!txLevel) begin
                    count_d = '0;
                end else if (count_q == IDLE_LAST) begin
                    state_d = PASS;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            PASS: begin
                count_d = '0;
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase
        if (!reqSync2_q) begin
            state_d = RST_HOLD;
            count_d = '0;
        end
        if (state_d != state_q) begin
            count_d = '0;
        end
    end

    // Output values are decoded from the next state so the registered outputs line up with the state register.
    always_comb begin
        rstOut_d    = (state_d != RST_HOLD);
        ctsN_d      = (state_d != PASS);
        gate_d      = (state_d == PASS);
        sin_d       = (state_d == PASS) ? txLevel : 1'b1;
        rx_d        = (state_d != RST_HOLD && rs232_sout_oe_in) ? rs232_sout_in : 1'b1;
        dropCount_d = dropCount_q;
        if (state_d == RST_HOLD) begin
            dropCount_d = '0;
        end else if ((state_q == BOOT_MASK || state_q == WAIT_IDLE) &&
                     txLevelPrev_q && !txLevel && (dropCount_q != '1)) begin
            dropCount_d = dropCount_q + DROP_W'(1);
        end
    end

    // Output registers so no pin ever sees combinational glitches.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rstOut_q    <= 1'b0;
            sin_q       <= 1'b1;
            rx_q        <= 1'b1;
            ctsN_q      <= 1'b1;
            gate_q      <= 1'b0;
            dropCount_q <= '0;
        end else begin
            rstOut_q    <= rstOut_d;
            sin_q       <= sin_d;
            rx_q        <= rx_d;
            ctsN_q      <= ctsN_d;
            gate_q      <= gate_d;
            dropCount_q <= dropCount_d;
        end
    end

    assign wifi_rst_n_out  = rstOut_q;
    assign rs232_sin_out   = sin_q;
    assign wifi_rx_out     = rx_q;
    assign rs232_cts_n_out = ctsN_q;
    assign gate_open       = gate_q;
    assign drop_count      = dropCount_q;

endmodule

// File: tb/tb_wifi_serial_gate.sv
// Directed bench for wifi_serial_gate with shortened timing parameters.
module tb_wifi_serial_gate;

    logic       clk;
    logic       resetN;
    logic       reqN;
    logic       rstOut;
    logic       tx;
    logic       sin;
    logic       sout;
    logic       soutOe;
    logic       rx;
    logic       ctsN;
    logic       gate;
    logic [7:0] drop;

    int checks = 0;
    int errors = 0;

    wifi_serial_gate #(
        .MIN_RST_CYCLES   (10),
        .BOOT_MASK_CYCLES (100),
        .IDLE_CYCLES      (20),
        .FILTER_LEN       (3),
        .CNT_W            (24)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (resetN),
        .wifi_rst_n_in    (reqN),
        .wifi_rst_n_out   (rstOut),
        .wifi_tx_in       (tx),
        .rs232_sin_out    (sin),
        .rs232_sout_in    (sout),
        .rs232_sout_oe_in (soutOe),
        .wifi_rx_out      (rx),
        .rs232_cts_n_out  (ctsN),
        .gate_open        (gate),
        .drop_count       (drop)
    );

    // Free-running 100 MHz clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drop the request for a few cycles and raise it again; returns on the first BOOT_MASK cycle.
    task automatic restart_module();
        reqN = 1'b0;
        tick(4);
        reqN = 1'b1;
        tick(13);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (rstOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_rst_out actual=%b expected=0", rstOut); end
        checks++;
        if (sin !== 1'b1) begin errors++; $display("[TB] FAIL reset_sin actual=%b expected=1", sin); end
        checks++;
        if (rx !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx actual=%b expected=1", rx); end
        checks++;
        if (ctsN !== 1'b1) begin errors++; $display("[TB] FAIL reset_cts_n actual=%b expected=1", ctsN); end
        checks++;
        if (gate !== 1'b0) begin errors++; $display("[TB] FAIL reset_gate actual=%b expected=0", gate); end
        checks++;
        if (drop !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop actual=%0d expected=0", drop); end
        resetN = 1'b1;
    endtask

    task automatic test_power_up();
        tick(5);
        reqN = 1'b1;
        for (int i = 1; i <= 140; i++) begin
            tick(1);
            checks++;
            if (rstOut !== (i >= 13)) begin
                errors++;
                $display("[TB] FAIL powerup_rst_out cycle=%0d actual=%b expected=%b", i, rstOut, (i >= 13));
            end
            checks++;
            if (gate !== (i >= 133)) begin
                errors++;
                $display("[TB] FAIL powerup_gate cycle=%0d actual=%b expected=%b", i, gate, (i >= 133));
            end
        end
    endtask

    task automatic test_boot_mask();
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        restart_module();
        checks++;
        if (rstOut !== 1'b1) begin errors++; $display("[TB] FAIL boot_rst_out actual=%b expected=1", rstOut); end
        for (int b = 0; b < 10; b++) begin
            tx = frame[b];
            for (int k = 0; k < 4; k++) begin
                tick(1);
                checks++;
                if (sin !== 1'b1 || ctsN !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL boot_masked bit=%0d sin=%b cts_n=%b expected sin=1 cts_n=1", b, sin, ctsN);
                end
            end
        end
        tick(10);
        checks++;
        if (drop !== 8'd5) begin errors++; $display("[TB] FAIL boot_drop actual=%0d expected=5", drop); end
    endtask

    task automatic test_idle_guard();
        restart_module();
        tick(90);
        tx = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            checks++;
            if (gate !== 1'b0 || sin !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle_low_gate cycle=%0d gate=%b sin=%b expected gate=0 sin=1", i, gate, sin);
            end
        end
        checks++;
        if (drop !== 8'd1) begin errors++; $display("[TB] FAIL idle_drop actual=%0d expected=1", drop); end
        tx = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick(1);
            checks++;
            if (gate !== (i >= 25)) begin
                errors++;
                $display("[TB] FAIL idle_gate_open cycle=%0d actual=%b expected=%b", i, gate, (i >= 25));
            end
        end
    endtask

    task automatic test_pass_glitch();
        tick(2);
        for (int w = 1; w <= 2; w++) begin
            tx = 1'b0;
            tick(w);
            tx = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                checks++;
                if (sin !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL glitch_w%0d_sin cycle=%0d actual=%b expected=1", w, i, sin);
                end
            end
        end
        tx = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            checks++;
            if (sin !== !(i >= 6 && i <= 8)) begin
                errors++;
                $display("[TB] FAIL pulse3_sin cycle=%0d actual=%b expected=%b", i, sin, !(i >= 6 && i <= 8));
            end
            if (i == 3) tx = 1'b1;
        end
    endtask

    task automatic test_reset_request();
        tx = 1'b0;
        tick(7);
        checks++;
        if (sin !== 1'b0) begin errors++; $display("[TB] FAIL midbyte_sin actual=%b expected=0", sin); end
        reqN = 1'b0;
        tick(2);
        checks++;
        if (gate !== 1'b1 || sin !== 1'b0 || drop !== 8'd1) begin
            errors++;
            $display("[TB] FAIL req_before gate=%b sin=%b drop=%0d expected gate=1 sin=0 drop=1", gate, sin, drop);
        end
        tick(1);
        checks++;
        if (gate !== 1'b0) begin errors++; $display("[TB] FAIL req_gate actual=%b expected=0", gate); end
        checks++;
        if (sin !== 1'b1) begin errors++; $display("[TB] FAIL req_sin actual=%b expected=1", sin); end
        checks++;
        if (ctsN !== 1'b1) begin errors++; $display("[TB] FAIL req_cts_n actual=%b expected=1", ctsN); end
        checks++;
        if (rstOut !== 1'b0) begin errors++; $display("[TB] FAIL req_rst_out actual=%b expected=0", rstOut); end
        checks++;
        if (drop !== 8'd0) begin errors++; $display("[TB] FAIL req_drop actual=%0d expected=0", drop); end
        tx     = 1'b1;
        soutOe = 1'b1;
        sout   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            checks++;
            if (rstOut !== 1'b0 || rx !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_low cycle=%0d rst_out=%b rx=%b expected rst_out=0 rx=1", i, rstOut, rx);
            end
        end
    endtask

    task automatic test_rx_and_async_reset();
        reqN = 1'b1;
        tick(13);
        soutOe = 1'b0;
        sout   = 1'b0;
        tick(1);
        checks++;
        if (rx !== 1'b1) begin errors++; $display("[TB] FAIL rx_oe0 actual=%b expected=1", rx); end
        soutOe = 1'b1;
        tick(1);
        checks++;
        if (rx !== 1'b0) begin errors++; $display("[TB] FAIL rx_oe1 actual=%b expected=0", rx); end
        sout = 1'b1;
        tick(1);
        checks++;
        if (rx !== 1'b1) begin errors++; $display("[TB] FAIL rx_sout1 actual=%b expected=1", rx); end
        sout = 1'b0;
        tick(120);
        checks++;
        if (gate !== 1'b1 || rx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_again gate=%b rx=%b expected gate=1 rx=0", gate, rx);
        end
        tx = 1'b0;
        tick(7);
        checks++;
        if (sin !== 1'b0 || ctsN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_midbyte sin=%b cts_n=%b expected sin=0 cts_n=0", sin, ctsN);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (rstOut !== 1'b0 || sin !== 1'b1 || rx !== 1'b1 || ctsN !== 1'b1 || gate !== 1'b0 || drop !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset rst_out=%b sin=%b rx=%b cts_n=%b gate=%b drop=%0d expected 0 1 1 1 0 0",
                     rstOut, sin, rx, ctsN, gate, drop);
        end
        tx = 1'b1;
        tick(2);
        resetN = 1'b1;
        tick(2);
    endtask

    // Scenario sequence; each scenario leaves the DUT where the next one expects it.
    initial begin
        resetN = 1'b1;
        reqN   = 1'b0;
        tx     = 1'b1;
        sout   = 1'b1;
        soutOe = 1'b0;
        #1 resetN = 1'b0;
        test_reset();
        test_power_up();
        test_boot_mask();
        test_idle_guard();
        test_pass_glitch();
        test_reset_request();
        test_rx_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
